// File: rtl/car_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : car_sequencer_pkg
// Purpose  : Shared state encodings, direction codes and floor-count default.
// Revision : 1.0
// ============================================================================
package car_sequencer_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_MOVING    = 2'd1;
  localparam logic [1:0] ST_DOOR_OPEN = 2'd2;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int DEFAULT_FLOORS = 8;

endpackage
`default_nettype wire

// File: rtl/car_sequencer_call_scan.sv
`default_nettype none
// ============================================================================
// Module   : car_sequencer_call_scan
// Purpose  : Classifies pending calls as here / ahead / behind a floor.
// Revision : 1.0
// ============================================================================
module car_sequencer_call_scan
  import car_sequencer_pkg::*;
#(
  parameter int FLOORS  = DEFAULT_FLOORS,
  parameter int FLOOR_W = 3
) (
  input  logic [FLOORS-1:0]  calls_i,
  input  logic [FLOOR_W-1:0] floor_i,
  input  logic               dir_i,
  output logic               here_o,
  output logic               ahead_o,
  output logic               behind_o
);

  logic [FLOORS-1:0] w_here_bits;
  logic [FLOORS-1:0] w_above_bits;
  logic [FLOORS-1:0] w_below_bits;
  logic              w_above;
  logic              w_below;

  for (genvar i = 0; i < FLOORS; i++) begin : g_bit
    assign w_here_bits[i]  = calls_i[i] && (FLOOR_W'(i) == floor_i);
    assign w_above_bits[i] = calls_i[i] && (FLOOR_W'(i) >  floor_i);
    assign w_below_bits[i] = calls_i[i] && (FLOOR_W'(i) <  floor_i);
  end

  assign w_above  = |w_above_bits;
  assign w_below  = |w_below_bits;
  assign here_o   = |w_here_bits;
  assign ahead_o  = (dir_i == DIR_UP) ? w_above : w_below;
  assign behind_o = (dir_i == DIR_UP) ? w_below : w_above;

endmodule
`default_nettype wire

// File: rtl/car_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : car_sequencer
// Purpose  : SCAN-policy motion and door sequencer for the elevator car.
// Revision : 1.0
// ============================================================================
module car_sequencer
  import car_sequencer_pkg::*;
#(
  parameter int FLOORS  = DEFAULT_FLOORS,
  parameter int FLOOR_W = 3,
  parameter int TRAVEL  = 8,
  parameter int DWELL   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOORS-1:0]  call_all,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic               direction,
  output logic               moving,
  output logic               door_open,
  output logic               floor_reached,
  output logic [FLOORS-1:0]  clear_mask
);

  localparam int CNT_MAX = (TRAVEL > DWELL) ? TRAVEL : DWELL;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] C_TRAVEL_LOAD = CNT_W'(TRAVEL - 1);
  localparam logic [CNT_W-1:0] C_DWELL_LOAD  = CNT_W'(DWELL - 1);

  logic [1:0]         state_q,   state_d;
  logic [FLOOR_W-1:0] floor_q,   floor_d;
  logic               dir_q,     dir_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               reached_q, reached_d;
  logic               moving_q;
  logic               door_q;
  logic [FLOORS-1:0]  clear_q,   clear_d;

  logic [FLOORS-1:0]  w_cur_onehot;
  logic [FLOORS-1:0]  w_new_onehot;
  logic [FLOORS-1:0]  w_scan_calls;
  logic [FLOOR_W-1:0] w_next_floor;
  logic               w_here_cur, w_ahead_cur, w_behind_cur;
  logic               w_here_nxt, w_ahead_nxt;

  for (genvar i = 0; i < FLOORS; i++) begin : g_onehot
    assign w_cur_onehot[i] = (floor_q == FLOOR_W'(i));
    assign w_new_onehot[i] = (floor_d == FLOOR_W'(i));
  end

  // The served bit lingers one cycle in the register file, so hide it while the door is open.
  assign w_scan_calls = (state_q == ST_DOOR_OPEN) ? (call_all & ~w_cur_onehot) : call_all;
  assign w_next_floor = (dir_q == DIR_UP) ? (floor_q + FLOOR_W'(1)) : (floor_q - FLOOR_W'(1));

  car_sequencer_call_scan #(
    .FLOORS  (FLOORS),
    .FLOOR_W (FLOOR_W)
  ) u_scan_cur (
    .calls_i  (w_scan_calls),
    .floor_i  (floor_q),
    .dir_i    (dir_q),
    .here_o   (w_here_cur),
    .ahead_o  (w_ahead_cur),
    .behind_o (w_behind_cur)
  );

  car_sequencer_call_scan #(
    .FLOORS  (FLOORS),
    .FLOOR_W (FLOOR_W)
  ) u_scan_next (
    .calls_i  (call_all),
    .floor_i  (w_next_floor),
    .dir_i    (dir_q),
    .here_o   (w_here_nxt),
    .ahead_o  (w_ahead_nxt),
    .behind_o ()
  );

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    reached_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_here_cur) begin
          state_d = ST_DOOR_OPEN;
          cnt_d   = C_DWELL_LOAD;
        end else if (w_ahead_cur) begin
          state_d = ST_MOVING;
          cnt_d   = C_TRAVEL_LOAD;
        end else if (w_behind_cur) begin
          state_d = ST_MOVING;
          dir_d   = ~dir_q;
          cnt_d   = C_TRAVEL_LOAD;
        end
      end
      ST_MOVING: begin
        if (cnt_q == '0) begin
          floor_d   = w_next_floor;
          reached_d = 1'b1;
          if (w_here_nxt) begin
            state_d = ST_DOOR_OPEN;
            cnt_d   = C_DWELL_LOAD;
          end else if (w_ahead_nxt) begin
            cnt_d   = C_TRAVEL_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DOOR_OPEN: begin
        if (cnt_q == '0) begin
          if (w_ahead_cur) begin
            state_d = ST_MOVING;
            cnt_d   = C_TRAVEL_LOAD;
          end else if (w_behind_cur) begin
            state_d = ST_MOVING;
            dir_d   = ~dir_q;
            cnt_d   = C_TRAVEL_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign clear_d = (state_d == ST_DOOR_OPEN) ? w_new_onehot : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      floor_q   <= '0;
      dir_q     <= DIR_UP;
      cnt_q     <= '0;
      reached_q <= 1'b0;
      moving_q  <= 1'b0;
      door_q    <= 1'b0;
      clear_q   <= '0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      reached_q <= reached_d;
      moving_q  <= (state_d == ST_MOVING);
      door_q    <= (state_d == ST_DOOR_OPEN);
      clear_q   <= clear_d;
    end
  end

  assign cur_floor     = floor_q;
  assign direction     = dir_q;
  assign moving        = moving_q;
  assign door_open     = door_q;
  assign floor_reached = reached_q;
  assign clear_mask    = clear_q;

endmodule
`default_nettype wire

// File: tb/tb_car_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_car_sequencer
// Purpose  : Directed self-checking bench for car_sequencer (TRAVEL 4, DWELL 3).
// Revision : 1.0
// ============================================================================
module tb_car_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] call_all;
  logic [2:0] cur_floor;
  logic       direction;
  logic       moving;
  logic       door_open;
  logic       floor_reached;
  logic [7:0] clear_mask;

  logic [7:0] calls_q;
  logic [7:0] press;
  int         n_checks;
  int         n_errors;

  car_sequencer #(
    .FLOORS  (8),
    .FLOOR_W (3),
    .TRAVEL  (4),
    .DWELL   (3)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .call_all      (call_all),
    .cur_floor     (cur_floor),
    .direction     (direction),
    .moving        (moving),
    .door_open     (door_open),
    .floor_reached (floor_reached),
    .clear_mask    (clear_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Minimal call register file: presses latch, clear_mask retires (clear wins).
  always @(posedge clk) begin
    if (reset) calls_q <= '0;
    else       calls_q <= (calls_q | press) & ~clear_mask;
  end
  assign call_all = calls_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic press_calls(input logic [7:0] mask);
    press = mask;
    step();
    press = '0;
  endtask

  // Follows the car until it settles in IDLE, collecting motion statistics.
  task automatic run_until_idle(output int mv, output int dr, output logic [7:0] reached,
                                output logic [31:0] stops, output logic bad, output logic ok);
    logic prev_door;
    mv = 0; dr = 0; reached = '0; stops = '0; bad = 1'b0; ok = 1'b0;
    prev_door = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!moving && !door_open) begin
        ok = 1'b1;
        break;
      end
      if (moving) mv++;
      if (door_open) dr++;
      if (floor_reached) reached[cur_floor] = 1'b1;
      if (door_open && !prev_door) stops = {stops[27:0], 1'b0, cur_floor};
      if (door_open && clear_mask != (8'h01 << cur_floor)) bad = 1'b1;
      if (!door_open && clear_mask != 8'h00) bad = 1'b1;
      if (moving && door_open) bad = 1'b1;
      prev_door = door_open;
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          mv, dr, n;
    logic [7:0]  rm;
    logic [31:0] seq;
    logic        bad, ok;

    n_checks = 0;
    n_errors = 0;
    press    = '0;
    reset    = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // Quiet idle after reset
    bad = 1'b0;
    repeat (20) begin
      step();
      if (moving || door_open || floor_reached || clear_mask != 8'h00) bad = 1'b1;
    end
    check("idle_quiet", 32'(bad), 0);
    check("idle_floor", 32'(cur_floor), 0);
    check("idle_dir", 32'(direction), 1);

    // Floor 0 -> 3
    press_calls(8'h08);
    check("s2_lat0", 32'(moving), 0);
    step();
    check("s2_lat1", 32'(moving), 1);
    run_until_idle(mv, dr, rm, seq, bad, ok);
    check("s2_done", 32'(ok), 1);
    check("s2_moving_cycles", 32'(mv), 12);
    check("s2_door_cycles", 32'(dr), 3);
    check("s2_reached", 32'(rm), 32'h0E);
    check("s2_stops", seq, 32'h3);
    check("s2_clear", 32'(bad), 0);
    check("s2_floor", 32'(cur_floor), 3);

    // From 3 going up, calls at 5 and 1: serve 5 then reverse to 1
    press_calls(8'h22);
    step();
    run_until_idle(mv, dr, rm, seq, bad, ok);
    check("s3_done", 32'(ok), 1);
    check("s3_stops", seq, 32'h51);
    check("s3_moving_cycles", 32'(mv), 24);
    check("s3_door_cycles", 32'(dr), 6);
    check("s3_reached", 32'(rm), 32'h3E);
    check("s3_clear", 32'(bad), 0);
    check("s3_floor", 32'(cur_floor), 1);
    check("s3_dir", 32'(direction), 0);

    // Reposition to floor 4 heading up (behind call toggles direction)
    press_calls(8'h10);
    step();
    run_until_idle(mv, dr, rm, seq, bad, ok);
    check("s5_prep_moving", 32'(mv), 12);
    check("s5_prep_floor", 32'(cur_floor), 4);
    check("s5_prep_dir", 32'(direction), 1);

    // Calls at 2 and 6 from floor 4 heading up: 6 first
    press_calls(8'h44);
    step();
    run_until_idle(mv, dr, rm, seq, bad, ok);
    check("s5_done", 32'(ok), 1);
    check("s5_stops", seq, 32'h62);
    check("s5_moving_cycles", 32'(mv), 24);
    check("s5_door_cycles", 32'(dr), 6);
    check("s5_reached", 32'(rm), 32'h7C);
    check("s5_clear", 32'(bad), 0);
    check("s5_floor", 32'(cur_floor), 2);

    // Top floor with re-press during dwell
    press_calls(8'h80);
    n = 0;
    while (!door_open && n < 200) begin
      step();
      n++;
    end
    check("s4_arrive", 32'(door_open), 1);
    check("s4_floor", 32'(cur_floor), 7);
    dr = 0; bad = 1'b0; n = 0;
    while (door_open && n < 20) begin
      dr++;
      if (clear_mask != 8'h80 || moving) bad = 1'b1;
      press = 8'h80;
      step();
      n++;
    end
    press = '0;
    check("s4_door_cycles", 32'(dr), 3);
    check("s4_clear", 32'(bad), 0);
    bad = 1'b0;
    repeat (5) begin
      if (moving || door_open || clear_mask != 8'h00) bad = 1'b1;
      step();
    end
    check("s4_stays_idle", 32'(bad), 0);
    check("s4_calls_retired", 32'(calls_q), 0);
    check("s4_floor_after", 32'(cur_floor), 7);

    // Reset while travelling down from 7 with travel_cnt at 2
    press_calls(8'h01);
    step();
    check("s6_moving", 32'(moving), 1);
    step();
    check("s6_floor_before", 32'(cur_floor), 7);
    check("s6_dir_before", 32'(direction), 0);
    reset = 1'b1;
    step();
    check("s6_moving_rst", 32'(moving), 0);
    check("s6_door_rst", 32'(door_open), 0);
    check("s6_floor_rst", 32'(cur_floor), 0);
    check("s6_reached_rst", 32'(floor_reached), 0);
    check("s6_dir_rst", 32'(direction), 1);
    check("s6_clear_rst", 32'(clear_mask), 0);
    reset = 1'b0;
    step();
    step();
    check("s6_idle_after", 32'({moving, door_open}), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
